// File: rtl/pio_in_edge.sv
// rtl/pio_in_edge.sv - Avalon-MM edge-capturing input port with level interrupt.
// Optional per-bit debounce filter is compiled in with PIO_IN_DEBOUNCE_EN.
module pio_in_edge #(
    parameter int WIDTH           = 1,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RESERVED = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] clear_mask;
    logic [31:0]      read_mux;

    // Reads are unconditional, and only the low WIDTH bits of writedata matter.
    logic unused_bus;
    assign unused_bus = ^{read, writedata};

`ifdef PIO_IN_DEBOUNCE_EN
    // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive cycle that s2
    // holds a value differing from filtered; any change restarts the window.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 2);

    logic [WIDTH-1:0] s2_d;
    logic [7:0]       db_cnt [WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_d     <= '0;
            filtered <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s2_d <= s2;
            for (int i = 0; i < WIDTH; i++) begin
                if ((s2[i] == filtered[i]) || (s2[i] != s2_d[i])) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    filtered[i] <= s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    assign filtered = s2;
`endif

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edges = filtered & ~prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edges = ~filtered & prev;
        end else begin : g_any
            assign edges = filtered ^ prev;
        end
    endgenerate

    assign clear_mask = (write && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux[WIDTH-1:0] = filtered;
            ADDR_RESERVED: read_mux            = '0;
            ADDR_IRQMASK:  read_mux[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP:  read_mux[WIDTH-1:0] = edgecapture;
            default:       read_mux            = '0;
        endcase
    end

    // Set-wins ordering: the OR with edges comes after the W1C clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1          <= '0;
            s2          <= '0;
            prev        <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            s1          <= in_port;
            s2          <= s1;
            prev        <= filtered;
            edgecapture <= (edgecapture & ~clear_mask) | edges;
            irq         <= |(edgecapture & irqmask);
            readdata    <= read_mux;
            if (write && (address == ADDR_IRQMASK)) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pio_in_edge.sv
// tb/tb_pio_in_edge.sv - Scoreboard bench for pio_in_edge, rising/falling/any instances side by side.
// Debounce checks run when PIO_IN_DEBOUNCE_EN is defined.
module tb_pio_in_edge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata_r, readdata_f, readdata_a;
    logic        irq_r, irq_f, irq_a;

    int vectors     = 0;
    int miscompares = 0;

    string       tag_q [$];
    int          sel_q [$];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    pio_in_edge #(.WIDTH(4), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(readdata_r), .irq(irq_r)
    );

    pio_in_edge #(.WIDTH(4), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(readdata_f), .irq(irq_f)
    );

    pio_in_edge #(.WIDTH(4), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .in_port(in_port), .readdata(readdata_a), .irq(irq_a)
    );

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            0:       return readdata_r;
            1:       return readdata_f;
            2:       return readdata_a;
            3:       return {31'd0, irq_r};
            4:       return {31'd0, irq_f};
            default: return {31'd0, irq_a};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        tag_q.push_back(tag);
        sel_q.push_back(sel);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        string       tag;
        int          sel;
        logic [31:0] exp;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            tag = tag_q.pop_front();
            sel = sel_q.pop_front();
            exp = exp_q.pop_front();
            obs = observed(sel);
            vectors++;
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_in(input logic [3:0] v);
        in_port = v;
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [31:0] er, input logic [31:0] ef, input logic [31:0] ea);
        address = a;
        read    = 1'b1;
        push({tag, "/rise"}, 0, er);
        push({tag, "/fall"}, 1, ef);
        push({tag, "/any"},  2, ea);
        tick();
        read = 1'b0;
    endtask

    task automatic irqs(input string tag, input logic er, input logic ef, input logic ea);
        push({tag, "/irq_rise"}, 3, {31'd0, er});
        push({tag, "/irq_fall"}, 4, {31'd0, ef});
        push({tag, "/irq_any"},  5, {31'd0, ea});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = '0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = '0;
        in_port   = '0;

        irqs("in_reset", 1'b0, 1'b0, 1'b0);
        rd("in_reset_cap", 2'd3, 0, 0, 0);
        tick();
        reset_n = 1'b1;

        rd("reserved", 2'd1, 0, 0, 0);
        wr(2'd1, 32'hFFFF_FFFF);
        rd("reserved_wr", 2'd1, 0, 0, 0);
        rd("mask_reset", 2'd2, 0, 0, 0);

`ifdef PIO_IN_DEBOUNCE_EN
        set_in(4'b0001);
        ticks(3);
        set_in(4'b0000);
        ticks(10);
        rd("glitch_data", 2'd0, 0, 0, 0);
        rd("glitch_cap", 2'd3, 0, 0, 0);

        set_in(4'b0001);
        ticks(8);
        rd("held_data", 2'd0, 1, 1, 1);
        rd("held_cap", 2'd3, 1, 0, 1);

        set_in(4'b0000);
        ticks(12);
        rd("release_data", 2'd0, 0, 0, 0);
        rd("release_cap", 2'd3, 1, 1, 1);
`else
        set_in(4'b0101);
        tick();
        tick();
        rd("data_k2", 2'd0, 5, 5, 5);
        irqs("mask0", 1'b0, 1'b0, 1'b0);
        rd("cap_k3", 2'd3, 5, 0, 5);
        wr(2'd3, 32'h1);
        rd("w1c_partial", 2'd3, 4, 0, 4);

        wr(2'd3, 32'hF);
        set_in(4'b0000);
        ticks(3);
        rd("cap_fall", 2'd3, 0, 5, 5);
        rd("data_zero", 2'd0, 0, 0, 0);
        wr(2'd3, 32'hF);

        wr(2'd2, 32'hFFFF_FFF1);
        rd("mask_low_bits", 2'd2, 1, 1, 1);
        set_in(4'b0001);
        tick();
        tick();
        irqs("irq_k2", 1'b0, 1'b0, 1'b0);
        tick();
        irqs("irq_k3", 1'b1, 1'b0, 1'b1);
        tick();
        irqs("irq_at_w1c", 1'b1, 1'b0, 1'b1);
        wr(2'd3, 32'h1);
        irqs("irq_after_w1c", 1'b0, 1'b0, 1'b0);
        tick();

        set_in(4'b0101);
        tick();
        tick();
        wr(2'd3, 32'h4);
        rd("set_wins", 2'd3, 4, 0, 4);
        wr(2'd3, 32'h4);
        rd("w1c_only", 2'd3, 0, 0, 0);

        set_in(4'b0111);
        ticks(3);
        rd("b1_rise", 2'd3, 2, 0, 2);
        wr(2'd3, 32'hF);
        set_in(4'b0101);
        ticks(3);
        rd("b1_fall", 2'd3, 0, 2, 2);
        wr(2'd3, 32'hF);

        wr(2'd2, 32'hF);
        set_in(4'b0000);
        ticks(3);
        set_in(4'b1111);
        ticks(3);
        irqs("irq_full", 1'b1, 1'b1, 1'b1);
        rd("cap_full", 2'd3, 32'hF, 5, 32'hF);

        #2;
        reset_n = 1'b0;
        #1;
        irqs("async_rst", 1'b0, 1'b0, 1'b0);
        push("async_rst/rd_rise", 0, 0);
        push("async_rst/rd_fall", 1, 0);
        push("async_rst/rd_any",  2, 0);
        drain();
        tick();
        reset_n = 1'b1;

        irqs("post_rst", 1'b0, 1'b0, 1'b0);
        rd("post_rst_cap", 2'd3, 0, 0, 0);
        tick();
        tick();
        rd("held_through_rst", 2'd3, 32'hF, 0, 32'hF);
        rd("mask_after_rst", 2'd2, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
